// File: rtl/vram_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vram_clear_sequencer
// Purpose  : Fills text VRAM (whole screen or one line) with blank cells and
//            merges CPU cell writes onto the same registered VRAM write port.
// Revision : 1.0 - initial release
// ============================================================================
module vram_clear_sequencer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_W     = 12,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  localparam int         ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  input  logic              mode,
  input  logic [ROW_W-1:0]  cursor_row,
  input  logic [15:0]       color_data,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [23:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [23:0]       vram_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_CLEAR = 2'd1;
  localparam logic [1:0] C_DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] C_COLS      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] C_LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic              start_q;
  logic              start_edge;
  logic              row_invalid;

  logic              mode_q, mode_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [15:0]       color_q, color_d;

  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [23:0]       vram_wdata_q, vram_wdata_d;

  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] last_addr;

  assign start_edge  = clear_start & ~start_q;
  assign row_invalid = (int'(cursor_row) >= ROWS);

  // First address comes from the live inputs (same cycle they are latched);
  // the end address is derived from the latched copies for the whole run.
  assign start_addr = mode ? (ADDR_W'(cursor_row) * C_COLS) : '0;
  assign last_addr  = mode_q ? (ADDR_W'(row_q) * C_COLS + C_COLS - C_ONE)
                             : C_LAST_CELL;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE: begin
        if (start_edge) begin
          state_d = (mode && row_invalid) ? C_DONE : C_CLEAR;
        end
      end
      C_CLEAR: begin
        if (vram_addr_q == last_addr) begin
          state_d = C_DONE;
        end
      end
      C_DONE: begin
        state_d = C_IDLE;
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output and datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_ready    = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    mode_d       = mode_q;
    row_d        = row_q;
    color_d      = color_q;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;

    unique case (state_q)
      C_IDLE: begin
        if (start_edge) begin
          // A clear wins over a simultaneous CPU write; the CPU keeps holding.
          cpu_ready = 1'b0;
          mode_d    = mode;
          row_d     = cursor_row;
          color_d   = color_data;
          if (!(mode && row_invalid)) begin
            vram_we_d    = 1'b1;
            vram_addr_d  = start_addr;
            vram_wdata_d = {BLANK_CHAR, color_data};
          end
        end else if (cpu_we) begin
          vram_we_d    = 1'b1;
          vram_addr_d  = cpu_addr;
          vram_wdata_d = cpu_wdata;
        end
      end
      C_CLEAR: begin
        cpu_ready = 1'b0;
        busy      = 1'b1;
        if (vram_addr_q != last_addr) begin
          vram_we_d    = 1'b1;
          vram_addr_d  = vram_addr_q + C_ONE;
          vram_wdata_d = {BLANK_CHAR, color_q};
        end
      end
      C_DONE: begin
        done = 1'b1;
        if (cpu_we) begin
          vram_we_d    = 1'b1;
          vram_addr_d  = cpu_addr;
          vram_wdata_d = cpu_wdata;
        end
      end
      default: begin
        cpu_ready = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // start_q resets high so a level held through reset is not an edge.
      start_q      <= 1'b1;
      mode_q       <= 1'b0;
      row_q        <= '0;
      color_q      <= '0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
    end else begin
      start_q      <= clear_start;
      mode_q       <= mode_d;
      row_q        <= row_d;
      color_q      <= color_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
    end
  end

  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_clear_sequencer
// Purpose  : Self-checking bench for vram_clear_sequencer (COLS=4, ROWS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_clear_sequencer;

  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int ADDR_W = 12;
  localparam int CELLS  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_start;
  logic              mode;
  logic [1:0]        cursor_row;
  logic [15:0]       color_data;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [23:0]       cpu_wdata;
  logic              cpu_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [23:0]       vram_wdata;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  vram_clear_sequencer #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_W     (ADDR_W),
    .BLANK_CHAR (8'h20)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .clear_start (clear_start),
    .mode        (mode),
    .cursor_row  (cursor_row),
    .color_data  (color_data),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observed activity, written only by the monitor.
  int                cyc = 0;
  logic [ADDR_W-1:0] wq_addr[$];
  logic [23:0]       wq_data[$];
  int                wq_cyc[$];
  int                busy_cnt = 0;
  int                done_cnt = 0;
  int                done_cyc = -1;
  int                ready_lo_cnt = 0;
  int                edge_cyc = -1;
  int                oob_cnt = 0;
  logic              prev_start = 1'b1;
  logic [23:0]       dut_mem[CELLS];

  // Reference screen image, written only by the stimulus process.
  logic [23:0]       ref_mem[CELLS];

  initial begin
    for (int i = 0; i < CELLS; i++) dut_mem[i] = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (clear_start && !prev_start) edge_cyc = cyc;
      prev_start = clear_start;
      if (vram_we) begin
        wq_addr.push_back(vram_addr);
        wq_data.push_back(vram_wdata);
        wq_cyc.push_back(cyc);
        if (int'(vram_addr) < CELLS) dut_mem[vram_addr] = vram_wdata;
        else oob_cnt++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cpu_we && !cpu_ready) ready_lo_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int base_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt > base_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_mem(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < CELLS; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
    check(name, mism, 0);
  endtask

  // Expected effect of a clear on the screen image, from the cell/row rule.
  task automatic model_clear(input logic m, input int r, input logic [15:0] col, output int covered);
    covered = 0;
    for (int a = 0; a < CELLS; a++) begin
      if (!m || (r < ROWS && (a / COLS) == r)) begin
        ref_mem[a] = {8'h20, col};
        covered++;
      end
    end
  endtask

  int snap_busy;
  int snap_done;

  // Issues one clear, scrambles the request inputs after they are sampled,
  // and returns the index of the first write it produced.
  task automatic run_clear(input logic m, input logic [1:0] r, input logic [15:0] col,
                           output int first_idx, output int n_wr);
    bit ok;
    @(negedge clk);
    first_idx  = wq_addr.size();
    snap_busy  = busy_cnt;
    snap_done  = done_cnt;
    mode       = m;
    cursor_row = r;
    color_data = col;
    clear_start = 1'b1;
    @(negedge clk);
    mode       = ~m;
    cursor_row = r + 2'd1;
    color_data = ~col;
    wait_done(snap_done, ok);
    check("done_seen", {31'd0, ok}, 1);
    @(negedge clk);
    clear_start = 1'b0;
    tick(2);
    n_wr = wq_addr.size() - first_idx;
  endtask

  typedef struct {
    logic        m;
    logic [1:0]  r;
    logic [15:0] col;
    int          exp_first;
    int          exp_n;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int  fi, nw, cov, bd, br;
    bit  ok;
    logic        rm;
    logic [1:0]  rr;
    logic [15:0] rc;
    logic [ADDR_W-1:0] ra;
    logic [23:0] rd;

    tbl[0] = '{1'b0, 2'd0, 16'hFF00, 0, 12};
    tbl[1] = '{1'b1, 2'd2, 16'h1E01, 8, 4};
    tbl[2] = '{1'b1, 2'd0, 16'h0F0F, 0, 4};
    tbl[3] = '{1'b1, 2'd1, 16'hA55A, 4, 4};
    tbl[4] = '{1'b1, 2'd3, 16'h1234, 0, 0};

    for (int i = 0; i < CELLS; i++) ref_mem[i] = '0;

    // Reset with clear_start held high throughout
    rst = 1'b1; clear_start = 1'b1; mode = 1'b0; cursor_row = '0; color_data = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk); #2;
    check("rst_vram_we", {31'd0, vram_we}, 0);
    check("rst_vram_addr", {20'd0, vram_addr}, 0);
    check("rst_vram_wdata", {8'd0, vram_wdata}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 1);
    tick(5);
    check("held_start_no_clear", wq_addr.size(), 0);
    clear_start = 1'b0;
    tick(2);

    // Table of clear requests
    for (int t = 0; t < 5; t++) begin
      run_clear(tbl[t].m, tbl[t].r, tbl[t].col, fi, nw);
      check("tbl_n_writes", nw, tbl[t].exp_n);
      for (int i = 0; i < nw && i < tbl[t].exp_n; i++) begin
        check("tbl_addr", {20'd0, wq_addr[fi+i]}, tbl[t].exp_first + i);
        check("tbl_data", {8'd0, wq_data[fi+i]}, {8'd0, 8'h20, tbl[t].col});
        check("tbl_write_cycle", wq_cyc[fi+i], edge_cyc + 1 + i);
      end
      check("tbl_busy_cycles", busy_cnt - snap_busy, tbl[t].exp_n);
      check("tbl_done_pulses", done_cnt - snap_done, 1);
      check("tbl_done_cycle", done_cyc, edge_cyc + tbl[t].exp_n + 1);
      model_clear(tbl[t].m, int'(tbl[t].r), tbl[t].col, cov);
      check_mem("tbl_mem_image");
    end

    // Second edge during CLEAR is ignored
    @(negedge clk);
    fi = wq_addr.size(); bd = done_cnt;
    mode = 1'b0; color_data = 16'h0707; clear_start = 1'b1;
    tick(4);
    clear_start = 1'b0;
    @(negedge clk);
    clear_start = 1'b1;
    wait_done(bd, ok);
    check("reedge_done_seen", {31'd0, ok}, 1);
    @(negedge clk);
    clear_start = 1'b0;
    tick(4);
    check("reedge_writes", wq_addr.size() - fi, 12);
    check("reedge_done_pulses", done_cnt - bd, 1);
    model_clear(1'b0, 0, 16'h0707, cov);
    check_mem("reedge_mem_image");

    // CPU write held through a screen clear
    @(negedge clk);
    fi = wq_addr.size(); bd = done_cnt; br = ready_lo_cnt;
    mode = 1'b0; color_data = 16'hFF00; clear_start = 1'b1;
    cpu_we = 1'b1; cpu_addr = 12'd5; cpu_wdata = 24'h41FF00;
    wait_done(bd, ok);
    check("cpu_hold_done_seen", {31'd0, ok}, 1);
    @(negedge clk);
    cpu_we = 1'b0; clear_start = 1'b0;
    tick(3);
    check("cpu_hold_ready_low", ready_lo_cnt - br, 13);
    nw = wq_addr.size() - fi;
    check("cpu_hold_writes", nw, 13);
    if (nw > 0) begin
      check("cpu_hold_addr", {20'd0, wq_addr[fi+nw-1]}, 5);
      check("cpu_hold_data", {8'd0, wq_data[fi+nw-1]}, 32'h0041FF00);
      check("cpu_hold_cycle", wq_cyc[fi+nw-1], done_cyc + 1);
    end
    model_clear(1'b0, 0, 16'hFF00, cov);
    ref_mem[5] = 24'h41FF00;
    check_mem("cpu_hold_mem_image");

    // Reset in the middle of a clear
    @(negedge clk);
    fi = wq_addr.size(); bd = done_cnt;
    mode = 1'b0; color_data = 16'h3C3C; clear_start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (wq_addr.size() - fi >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    check("midrst_six_writes_seen", {31'd0, ok}, 1);
    rst = 1'b1;
    #1;
    check("midrst_vram_we", {31'd0, vram_we}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    tick(2);
    rst = 1'b0;
    tick(8);
    check("midrst_writes", wq_addr.size() - fi, 6);
    check("midrst_no_done", done_cnt - bd, 0);
    clear_start = 1'b0;
    tick(2);
    for (int a = 0; a < 6; a++) ref_mem[a] = 24'h203C3C;
    check_mem("midrst_mem_image");

    // Randomized mix of CPU writes and clears against the screen model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = 12'($urandom_range(0, CELLS - 1));
        rd = 24'($urandom);
        fi = wq_addr.size();
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = ra; cpu_wdata = rd;
        @(negedge clk);
        cpu_we = 1'b0;
        tick(2);
        ref_mem[ra] = rd;
        check("rnd_cpu_writes", wq_addr.size() - fi, 1);
        check_mem("rnd_cpu_mem_image");
      end else begin
        rm = 1'($urandom_range(0, 1));
        rr = 2'($urandom_range(0, 3));
        rc = 16'($urandom);
        run_clear(rm, rr, rc, fi, nw);
        model_clear(rm, int'(rr), rc, cov);
        check("rnd_clear_writes", nw, cov);
        check("rnd_clear_busy", busy_cnt - snap_busy, cov);
        check("rnd_clear_done", done_cnt - snap_done, 1);
        check_mem("rnd_clear_mem_image");
      end
    end

    check("no_out_of_range_writes", oob_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
